// File: rtl/touch_detector.sv
// Capacitive touch detector: averages a calibration baseline, then debounces
// press/release decisions with hysteresis and tracks slow baseline drift.
module touch_detector #(
   parameter int CAL_SHIFT     = 4,
   parameter int TOUCH_DELTA   = 500,
   parameter int RELEASE_DELTA = 250,
   parameter int DEBOUNCE      = 3
) (
   input  logic        clock_i,
   input  logic        resetn_i,
   input  logic [31:0] count_in_i,
   input  logic        count_valid_i,
   input  logic        recalibrate_i,
   output logic        touched_o,
   output logic        press_o,
   output logic        release_o,
   output logic        calibrated_o,
   output logic [31:0] baseline_o
);

   typedef enum logic [2:0] {
      CALIB      = 3'd0,
      RELEASED   = 3'd1,
      PRESS_PEND = 3'd2,
      PRESSED    = 3'd3,
      REL_PEND   = 3'd4
   } state_t;

   localparam int          SUM_W    = 32 + CAL_SHIFT;
   localparam logic [31:0] TOUCH_TH = 32'(TOUCH_DELTA);
   localparam logic [31:0] REL_TH   = 32'(RELEASE_DELTA);
   localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE);

   state_t               state_q, state_d;
   logic [SUM_W-1:0]     sum_q, sum_d, sum_add;
   logic [CAL_SHIFT-1:0] samp_q, samp_d;
   logic [3:0]           deb_q, deb_d, deb_inc;
   logic [31:0]          baseline_q, baseline_d, delta;
   logic                 touched_q, touched_d;
   logic                 press_q, press_d;
   logic                 release_q, release_d;
   logic                 cal_q, cal_d;
   logic                 is_touch, is_rel;

   // Saturating difference: readings below baseline never wrap to large deltas
   assign delta    = (count_in_i > baseline_q) ? (count_in_i - baseline_q) : 32'd0;
   assign is_touch = (delta >= TOUCH_TH);
   assign is_rel   = (delta < REL_TH);
   assign sum_add  = sum_q + SUM_W'(count_in_i);
   assign deb_inc  = deb_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      samp_d     = samp_q;
      deb_d      = deb_q;
      baseline_d = baseline_q;
      touched_d  = touched_q;
      cal_d      = cal_q;
      press_d    = 1'b0;
      release_d  = 1'b0;

      if (recalibrate_i) begin
         state_d   = CALIB;
         cal_d     = 1'b0;
         touched_d = 1'b0;
         deb_d     = 4'd0;
         sum_d     = '0;
         samp_d    = '0;
      end else if (count_valid_i) begin
         case (state_q)
            CALIB: begin
               if (samp_q == {CAL_SHIFT{1'b1}}) begin
                  baseline_d = sum_add[CAL_SHIFT +: 32];
                  cal_d      = 1'b1;
                  state_d    = RELEASED;
                  sum_d      = '0;
                  samp_d     = '0;
               end else begin
                  sum_d  = sum_add;
                  samp_d = samp_q + 1'b1;
               end
            end
            RELEASED: begin
               if (is_touch) begin
                  if (DEBOUNCE == 1) begin
                     state_d   = PRESSED;
                     touched_d = 1'b1;
                     press_d   = 1'b1;
                     deb_d     = 4'd0;
                  end else begin
                     state_d = PRESS_PEND;
                     deb_d   = 4'd1;
                  end
               end else if (count_in_i > baseline_q) begin
                  baseline_d = baseline_q + 32'd1;
               end else if (count_in_i < baseline_q) begin
                  baseline_d = baseline_q - 32'd1;
               end
            end
            PRESS_PEND: begin
               if (is_touch) begin
                  if (deb_inc == DEB_N) begin
                     state_d   = PRESSED;
                     touched_d = 1'b1;
                     press_d   = 1'b1;
                     deb_d     = 4'd0;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  state_d = RELEASED;
                  deb_d   = 4'd0;
               end
            end
            PRESSED: begin
               if (is_rel) begin
                  if (DEBOUNCE == 1) begin
                     state_d   = RELEASED;
                     touched_d = 1'b0;
                     release_d = 1'b1;
                     deb_d     = 4'd0;
                  end else begin
                     state_d = REL_PEND;
                     deb_d   = 4'd1;
                  end
               end
            end
            REL_PEND: begin
               if (is_rel) begin
                  if (deb_inc == DEB_N) begin
                     state_d   = RELEASED;
                     touched_d = 1'b0;
                     release_d = 1'b1;
                     deb_d     = 4'd0;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  state_d = PRESSED;
                  deb_d   = 4'd0;
               end
            end
            default: state_d = CALIB;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= CALIB;
         sum_q      <= '0;
         samp_q     <= '0;
         deb_q      <= 4'd0;
         baseline_q <= 32'd0;
         touched_q  <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         cal_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         samp_q     <= samp_d;
         deb_q      <= deb_d;
         baseline_q <= baseline_d;
         touched_q  <= touched_d;
         press_q    <= press_d;
         release_q  <= release_d;
         cal_q      <= cal_d;
      end
   end

   assign touched_o    = touched_q;
   assign press_o      = press_q;
   assign release_o    = release_q;
   assign calibrated_o = cal_q;
   assign baseline_o   = baseline_q;

endmodule

// File: tb/tb_touch_detector.sv
// Directed vector bench for touch_detector with default parameters.
module tb_touch_detector;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] count_in = 32'd0;
   logic        count_valid = 1'b0;
   logic        recalibrate = 1'b0;
   logic        touched, press, release_p, calibrated;
   logic [31:0] baseline;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rc;
      logic        vld;
      logic [31:0] cnt;
      logic        t;
      logic        p;
      logic        r;
      logic        c;
      logic [31:0] b;
   } vec_t;

   vec_t vecs[$];

   touch_detector dut (
      .clock_i       (clock),
      .resetn_i      (resetn),
      .count_in_i    (count_in),
      .count_valid_i (count_valid),
      .recalibrate_i (recalibrate),
      .touched_o     (touched),
      .press_o       (press),
      .release_o     (release_p),
      .calibrated_o  (calibrated),
      .baseline_o    (baseline)
   );

   always #5 clock = ~clock;

   function automatic void add(input logic rc, input logic vld, input logic [31:0] cnt,
                               input logic t, input logic p, input logic r,
                               input logic c, input logic [31:0] b);
      vec_t v;
      v.rc = rc; v.vld = vld; v.cnt = cnt;
      v.t = t; v.p = p; v.r = r; v.c = c; v.b = b;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input logic rc, input logic vld, input logic [31:0] cnt);
      @(negedge clock);
      recalibrate = rc;
      count_valid = vld;
      count_in    = cnt;
      @(posedge clock);
      #1;
      recalibrate = 1'b0;
      count_valid = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic t, input logic p, input logic r,
                            input logic c, input logic [31:0] b);
      check({tag, ".touched"},    32'(touched),    32'(t));
      check({tag, ".press"},      32'(press),      32'(p));
      check({tag, ".release"},    32'(release_p),  32'(r));
      check({tag, ".calibrated"}, 32'(calibrated), 32'(c));
      check({tag, ".baseline"},   baseline,        b);
   endtask

   task automatic calib_run(input string tag, input logic [31:0] val);
      for (int k = 0; k < 15; k++) apply(1'b0, 1'b1, val);
      check({tag, ".cal_before_16"}, 32'(calibrated), 32'd0);
      apply(1'b0, 1'b1, val);
      check({tag, ".cal_after_16"}, 32'(calibrated), 32'd1);
      check({tag, ".base_after_16"}, baseline, val);
   endtask

   initial begin
      // calibration: 16 x 1000
      for (int k = 0; k < 15; k++) add(0, 1, 1000, 0, 0, 0, 0, 0);
      add(0, 1, 1000, 0, 0, 0, 1, 1000);
      // no strobe: garbage count ignored
      add(0, 0, 99999, 0, 0, 0, 1, 1000);
      // press
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1600, 1, 1, 0, 1, 1000);
      add(0, 0, 0,    1, 0, 0, 1, 1000);
      // release
      add(0, 1, 1100, 1, 0, 0, 1, 1000);
      add(0, 1, 1100, 1, 0, 0, 1, 1000);
      add(0, 1, 1100, 0, 0, 1, 1, 1000);
      add(0, 0, 0,    0, 0, 0, 1, 1000);
      // aborted press; pending state freezes baseline
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1200, 0, 0, 0, 1, 1000);
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1600, 0, 0, 0, 1, 1000);
      add(0, 1, 1000, 0, 0, 0, 1, 1000);
      // drift tracking
      for (int k = 1; k <= 5; k++) add(0, 1, 1010, 0, 0, 0, 1, 32'(1000 + k));
      add(0, 1, 0,    0, 0, 0, 1, 1004);
      add(0, 1, 1004, 0, 0, 0, 1, 1004);
      // threshold boundaries at baseline 1004
      add(0, 1, 1504, 0, 0, 0, 1, 1004);
      add(0, 1, 1503, 0, 0, 0, 1, 1004);
      add(0, 1, 1504, 0, 0, 0, 1, 1004);
      add(0, 1, 1504, 0, 0, 0, 1, 1004);
      add(0, 1, 1504, 1, 1, 0, 1, 1004);
      add(0, 1, 1254, 1, 0, 0, 1, 1004);
      add(0, 1, 1253, 1, 0, 0, 1, 1004);
      add(0, 1, 1300, 1, 0, 0, 1, 1004);
      // recalibrate with coincident strobe while touched
      add(1, 1, 1000, 0, 0, 0, 0, 1004);
      for (int k = 0; k < 15; k++) add(0, 1, 2000, 0, 0, 0, 0, 1004);
      add(0, 1, 2000, 0, 0, 0, 1, 2000);

      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_all("reset", 0, 0, 0, 0, 0);
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rc, vecs[i].vld, vecs[i].cnt);
         check_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].p, vecs[i].r,
                   vecs[i].c, vecs[i].b);
      end

      // async reset between edges while in PRESS_PEND
      apply(1'b0, 1'b1, 32'd2600);
      check_all("pend", 0, 0, 0, 1, 2000);
      #2;
      resetn = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0);
      @(negedge clock);
      resetn = 1'b1;
      calib_run("post_rst", 32'd500);

      // reset mid-calibration discards the partial sum
      apply(1'b1, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) apply(1'b0, 1'b1, 32'd3000);
      @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      calib_run("mid_cal_rst", 32'd700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
